// File: rtl/regfile_sb.sv
// Integer register file with write-through forwarding and a per-register busy
// scoreboard; NRP combinational read ports, one write-back port, issue tracking.
module regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned AW       = $clog2(NREG),
    parameter int unsigned NRP      = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NRP-1:0]            i_re,
    input  logic [NRP*AW-1:0]         i_raddr,
    output logic [NRP*XLEN-1:0]       o_rdata,
    output logic [NRP-1:0]            o_rbusy,
    input  logic                      i_we,
    input  logic [AW-1:0]             i_waddr,
    input  logic [XLEN-1:0]           i_wdata,
    input  logic                      i_iss,
    input  logic [AW-1:0]             i_iss_rd,
    input  logic                      i_flush,
    output logic [$clog2(NREG):0]     o_busy_cnt
);

    localparam int unsigned CW = $clog2(NREG) + 1;

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [CW-1:0]   r_busy_cnt;

    logic            w_wr_en;
    logic [NREG-1:0] w_busy_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [AW-1:0]   w_ra [NRP];

    assign w_wr_en    = i_we && !(ZERO_REG && (i_waddr == '0));
    assign o_busy_cnt = r_busy_cnt;

    // Scoreboard next state: flush > issue (newer producer) > write-back clear.
    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt_nxt  = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (i_flush) begin
                w_busy_nxt[r] = 1'b0;
            end else if (i_iss && (i_iss_rd == AW'(r)) && !(ZERO_REG && (r == 0))) begin
                w_busy_nxt[r] = 1'b1;
            end else if (i_we && (i_waddr == AW'(r))) begin
                w_busy_nxt[r] = 1'b0;
            end
            w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[r]);
        end
    end

    // Read ports with same-cycle forwarding of the write-back data.
    always_comb begin
        o_rdata = '0;
        o_rbusy = '0;
        for (int unsigned i = 0; i < NRP; i++) begin
            w_ra[i] = i_raddr[i*AW +: AW];
            if (!i_re[i]) begin
                o_rdata[i*XLEN +: XLEN] = '0;
            end else if (ZERO_REG && (w_ra[i] == '0)) begin
                o_rdata[i*XLEN +: XLEN] = '0;
            end else if (i_we && (i_waddr == w_ra[i])) begin
                o_rdata[i*XLEN +: XLEN] = i_wdata;
            end else begin
                o_rdata[i*XLEN +: XLEN] = r_regs[w_ra[i]];
                o_rbusy[i]              = r_busy[w_ra[i]];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against an array-based model.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [5:0]  busy_cnt;

    int checks;
    int failures;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    regfile_sb dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_re       (re),
        .i_raddr    (raddr),
        .o_rdata    (rdata),
        .o_rbusy    (rbusy),
        .i_we       (we),
        .i_waddr    (waddr),
        .i_wdata    (wdata),
        .i_iss      (iss),
        .i_iss_rd   (iss_rd),
        .i_flush    (flush),
        .o_busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    task automatic exp_port(input int p, output logic [31:0] d, output logic b);
        logic [4:0] ra;
        ra = raddr[p*5 +: 5];
        d  = '0;
        b  = 1'b0;
        if (re[p] && ra != 5'd0) begin
            if (we && waddr == ra) begin
                d = wdata;
            end else begin
                d = m_regs[ra];
                b = m_busy[ra];
            end
        end
    endtask

    task automatic check_ports(input string tag);
        logic [31:0] d;
        logic        b;
        for (int p = 0; p < 2; p++) begin
            exp_port(p, d, b);
            check($sformatf("%s_rdata%0d", tag, p), rdata[p*32 +: 32], d);
            check($sformatf("%s_rbusy%0d", tag, p), 32'(rbusy[p]), 32'(b));
        end
    endtask

    // Check combinational outputs, clock once, advance the model, check busy_cnt.
    task automatic cycle(input string tag);
        #1;
        check_ports(tag);
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (we && waddr != 5'd0) m_regs[waddr] = wdata;
            if (flush) begin
                for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            end else begin
                if (we) m_busy[waddr] = 1'b0;
                if (iss && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
            end
        end
        #1;
        check($sformatf("%s_busy_cnt", tag), 32'(busy_cnt), 32'(model_cnt()));
    endtask

    task automatic idle();
        we = 1'b0; iss = 1'b0; flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_clear();
        rst_n = 1'b0;
        re = 2'b00; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
        iss = 1'b0; iss_rd = '0; flush = 1'b0;
        #2;

        // Preload attempt during reset: forwarded combinationally, never stored.
        re = 2'b11; raddr = {5'd0, 5'd3}; we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE0003;
        cycle("rst_fwd");
        check("rst_fwd_direct", rdata[31:0], 32'hCAFE0003);
        we = 1'b0;
        cycle("rst_hold");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        re = 2'b11; raddr = {5'd3, 5'd0};
        cycle("post_rst");
        check("post_rst_r3", rdata[63:32], 32'h0);

        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
        cycle("fwd");
        idle();
        cycle("fwd_store");
        check("fwd_store_direct", rdata[31:0], 32'hDEADBEEF);

        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
        cycle("x0_wr");
        idle(); iss = 1'b1; iss_rd = 5'd0;
        cycle("x0_iss");
        idle();
        cycle("x0_after");
        check("x0_cnt_direct", 32'(busy_cnt), 32'd0);

        iss = 1'b1; iss_rd = 5'd7;
        cycle("sb_iss");
        idle(); raddr = {5'd7, 5'd7};
        cycle("sb_busy");
        check("sb_busy_direct", 32'(rbusy), 32'd3);
        we = 1'b1; waddr = 5'd7; wdata = 32'h12;
        cycle("sb_wb");
        idle();
        cycle("sb_clear");

        iss = 1'b1; iss_rd = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        cycle("sim_iss_wb");
        idle(); raddr = {5'd9, 5'd9};
        cycle("sim_read");
        check("sim_busy_direct", 32'(rbusy[0]), 32'd1);
        iss = 1'b1; iss_rd = 5'd10;
        cycle("iss10");
        iss_rd = 5'd11;
        cycle("iss11");
        iss_rd = 5'd12; flush = 1'b1;
        cycle("iss12_flush");
        check("flush_cnt_direct", 32'(busy_cnt), 32'd0);

        for (int k = 0; k < 3; k++) begin
            idle(); iss = 1'b1; iss_rd = 5'(20 + k); we = 1'b1; waddr = 5'(20 + k);
            wdata = 32'h100 + 32'(k);
            cycle("pre_rst");
        end
        idle(); iss = 1'b1; iss_rd = 5'd23;
        cycle("pre_rst4");
        idle(); raddr = {5'd21, 5'd5};
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        check("mid_rst_cnt", 32'(busy_cnt), 32'd0);
        check_ports("mid_rst");
        for (int r = 1; r < 32; r++) begin
            raddr = {5'(r), 5'(r)};
            #0.1;
            check($sformatf("mid_rst_reg%0d", r), rdata[31:0], 32'h0);
        end
        rst_n = 1'b1;
        cycle("post_pulse");

        for (int n = 0; n < 400; n++) begin
            re     = 2'($urandom);
            raddr  = 10'($urandom);
            we     = ($urandom_range(0, 1) == 1);
            waddr  = 5'($urandom);
            wdata  = $urandom;
            iss    = ($urandom_range(0, 1) == 1);
            iss_rd = 5'($urandom);
            flush  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) raddr[4:0] = waddr;
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
